// File: rtl/password_controller.sv
// Password-protected lock controller.
// Two raw push-buttons (save, submit) are synchronized, debounced and turned
// into single-cycle press pulses. The mode switch is only synchronized.
// A four-state FSM (CLOSED / OPEN / ALARM / PROG) checks submitted codes
// against a stored password, relocks on a timer and locks out after repeated
// wrong attempts. All outputs are registered.

// Synchronizer + debouncer + press detector for one active-low button.
module pc_debounce #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_n,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [1:0]    sync_q;   // sync_q[1] is the synchronized level
   logic [1:0]    vld_q;    // marks when sync_q[1] holds a real sample
   logic          deb_q;    // debounced level, 1 = released
   logic          deb_d1;   // debounced level one cycle ago
   logic [CW-1:0] cnt_q;    // consecutive cycles sync differs from deb
   logic [CW-1:0] rel_q;    // consecutive released cycles seen before arming
   logic          armed_q;  // key has been seen released since reset

   // Two-flop synchronizer; idles at "released" during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         vld_q  <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments make each flop take the pre-edge value
         // of its neighbour; blocking ones would collapse the chain to one stage.
         sync_q <= {sync_q[0], raw_n};
         vld_q  <= {vld_q[0], 1'b1};
      end
   end

   // Debounced level follows sync only after DEB_CYCLES consecutive differing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q <= 1'b1;
         cnt_q <= '0;
      end else if (sync_q[1] != deb_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            deb_q <= sync_q[1];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end else begin
         cnt_q <= '0;
      end
   end

   // Arm press detection only after a clean release, so a key held through
   // reset never produces a pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q <= 1'b0;
         rel_q   <= '0;
      end else if (!armed_q) begin
         if (vld_q[1] && sync_q[1]) begin
            if (rel_q == CW'(DEB_CYCLES - 1)) armed_q <= 1'b1;
            else                              rel_q   <= rel_q + CW'(1);
         end else begin
            rel_q <= '0;
         end
      end
   end

   // Delayed debounced level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) deb_d1 <= 1'b1;
      else        deb_d1 <= deb_q;
   end

   assign press = armed_q & deb_d1 & ~deb_q;

endmodule

// Lock controller top level. MAX_TRIES is expected in 1..3.
module password_controller #(
   parameter int         DEB_CYCLES   = 50000,
   parameter int         OPEN_CYCLES  = 250000000,
   parameter int         LOCK_CYCLES  = 500000000,
   parameter int         BLINK_CYCLES = 12500000,
   parameter int         MAX_TRIES    = 3,
   parameter logic [7:0] RESET_PW     = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode,
   input  logic [7:0] in_code,
   input  logic       save_n,
   input  logic       submit_n,
   output logic [7:0] led,
   output logic       unlocked,
   output logic       alarm,
   output logic [1:0] state_dbg,
   output logic [1:0] tries_dbg
);

   localparam logic [1:0] S_CLOSED = 2'b00;
   localparam logic [1:0] S_OPEN   = 2'b01;
   localparam logic [1:0] S_ALARM  = 2'b10;
   localparam logic [1:0] S_PROG   = 2'b11;

   localparam int OW = $clog2(OPEN_CYCLES);
   localparam int LW = $clog2(LOCK_CYCLES);
   localparam int BW = $clog2(BLINK_CYCLES);

   localparam logic [OW-1:0] OPEN_LOAD  = OW'(OPEN_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCK_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 1);
   localparam logic [1:0]    TRIES_MAX  = 2'(MAX_TRIES);

   logic          save_p, submit_p;
   logic [1:0]    mode_q;
   logic          mode_s;

   logic [1:0]    state_q, state_n;
   logic [7:0]    pw_q, pw_n;
   logic [1:0]    tries_q, tries_n, tries_inc;
   logic [OW-1:0] open_q, open_n;
   logic [LW-1:0] lock_q, lock_n;
   logic [BW-1:0] blink_q, blink_n;
   logic          phase_q, phase_n;
   logic [7:0]    led_n;

   pc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_save (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_n (save_n),
      .press (save_p)
   );

   pc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_submit (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_n (submit_n),
      .press (submit_p)
   );

   // Mode switch synchronizer; idles at "user".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mode_q <= 2'b00;
      else        mode_q <= {mode_q[0], mode};
   end

   assign mode_s    = mode_q[1];
   assign tries_inc = (tries_q == 2'd3) ? 2'd3 : tries_q + 2'd1;

   // Next-state, password, attempt and timer logic.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_n = state_q;
      pw_n    = pw_q;
      tries_n = tries_q;
      open_n  = open_q;
      lock_n  = lock_q;
      blink_n = blink_q;
      phase_n = phase_q;
      case (state_q)
         S_CLOSED: begin
            if (submit_p) begin
               if (in_code == pw_q) begin
                  state_n = S_OPEN;
                  tries_n = 2'd0;
                  open_n  = OPEN_LOAD;
               end else begin
                  tries_n = tries_inc;
                  if (tries_inc == TRIES_MAX) begin
                     state_n = S_ALARM;
                     lock_n  = LOCK_LOAD;
                     blink_n = BLINK_LOAD;
                     phase_n = 1'b0;
                  end
               end
            end
         end
         S_OPEN: begin
            if (submit_p)            state_n = S_CLOSED;
            else if (mode_s)         state_n = S_PROG;
            else if (open_q == '0)   state_n = S_CLOSED;
            else                     open_n  = open_q - OW'(1);
         end
         S_PROG: begin
            if (save_p) pw_n    = in_code;
            if (!mode_s) state_n = S_CLOSED;
         end
         default: begin  // S_ALARM: inputs ignored until lockout expires
            if (lock_q == '0) begin
               state_n = S_CLOSED;
               tries_n = 2'd0;
            end else begin
               lock_n = lock_q - LW'(1);
               if (blink_q == '0) begin
                  blink_n = BLINK_LOAD;
                  phase_n = ~phase_q;
               end else begin
                  blink_n = blink_q - BW'(1);
               end
            end
         end
      endcase
   end

   // LED pattern for the state being entered.
   always_comb begin
      led_n = 8'h00;
      case (state_n)
         S_OPEN:  led_n = 8'hFF;
         S_PROG:  led_n = in_code;
         S_ALARM: led_n = phase_n ? 8'h55 : 8'hAA;
         default: led_n = 8'h00;
      endcase
   end

   // State, password, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_CLOSED;
         pw_q      <= RESET_PW;
         tries_q   <= 2'd0;
         open_q    <= '0;
         lock_q    <= '0;
         blink_q   <= '0;
         phase_q   <= 1'b0;
         led       <= 8'h00;
         unlocked  <= 1'b0;
         alarm     <= 1'b0;
         tries_dbg <= 2'd0;
      end else begin
         state_q   <= state_n;
         pw_q      <= pw_n;
         tries_q   <= tries_n;
         open_q    <= open_n;
         lock_q    <= lock_n;
         blink_q   <= blink_n;
         phase_q   <= phase_n;
         led       <= led_n;
         unlocked  <= (state_n == S_OPEN);
         alarm     <= (state_n == S_ALARM);
         tries_dbg <= tries_n;
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_password_controller.sv
// Directed testbench for password_controller with short timing parameters.
// Press latency from a raw key edge to the state change is 7 cycles:
// 2 synchronizer + 4 debounce + 1 FSM register.
module tb_password_controller;

   localparam logic [1:0] CLOSED = 2'b00;
   localparam logic [1:0] OPEN   = 2'b01;
   localparam logic [1:0] ALARM  = 2'b10;
   localparam logic [1:0] PROG   = 2'b11;

   logic       clk, rst_n, mode, save_n, submit_n;
   logic [7:0] in_code;
   logic [7:0] led;
   logic       unlocked, alarm;
   logic [1:0] state_dbg, tries_dbg;

   int n_pass  = 0;
   int n_total = 0;

   password_controller #(
      .DEB_CYCLES   (4),
      .OPEN_CYCLES  (20),
      .LOCK_CYCLES  (40),
      .BLINK_CYCLES (5),
      .MAX_TRIES    (3),
      .RESET_PW     (8'h00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_code   (in_code),
      .save_n    (save_n),
      .submit_n  (submit_n),
      .led       (led),
      .unlocked  (unlocked),
      .alarm     (alarm),
      .state_dbg (state_dbg),
      .tries_dbg (tries_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Wait up to budget cycles for state_dbg == exp; lat = cycles taken or -1.
   task automatic wait_state(input logic [1:0] exp, input int budget, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (state_dbg !== exp && lat < budget);
      if (state_dbg !== exp) lat = -1;
   endtask

   task automatic press_submit(input int hold);
      submit_n = 1'b0;
      tick(hold);
      submit_n = 1'b1;
      tick(10);
   endtask

   task automatic press_save(input int hold);
      save_n = 1'b0;
      tick(hold);
      save_n = 1'b1;
      tick(10);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; mode = 1'b0; save_n = 1'b1; submit_n = 1'b1; in_code = 8'h00;
      tick(3);
      n_total++; if (state_dbg !== CLOSED) $display("FAIL reset_state: got %b want %b", state_dbg, CLOSED); else n_pass++;
      n_total++; if (led !== 8'h00) $display("FAIL reset_led: got %h want 00", led); else n_pass++;
      n_total++; if ({unlocked, alarm} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {unlocked, alarm}); else n_pass++;
      n_total++; if (tries_dbg !== 2'd0) $display("FAIL reset_tries: got %0d want 0", tries_dbg); else n_pass++;
      rst_n = 1'b1;
      tick(10);
      n_total++; if (state_dbg !== CLOSED) $display("FAIL idle_after_reset: got %b want %b", state_dbg, CLOSED); else n_pass++;
   endtask

   task automatic test_open_timeout;
      int lat;
      int n_open;
      in_code  = 8'h00;
      submit_n = 1'b0;
      wait_state(OPEN, 20, lat);
      n_total++; if (lat !== 7) $display("FAIL open_latency: got %0d want 7", lat); else n_pass++;
      n_total++; if ({unlocked, alarm, led} !== {2'b10, 8'hFF}) $display("FAIL open_outputs: got %b %b %h want 1 0 ff", unlocked, alarm, led); else n_pass++;
      n_open = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (state_dbg !== OPEN) break;
         n_open++;
         if (n_open == 6) submit_n = 1'b1;
      end
      n_total++; if (n_open !== 20) $display("FAIL open_dwell: got %0d want 20", n_open); else n_pass++;
      n_total++; if ({state_dbg, led, unlocked} !== {CLOSED, 8'h00, 1'b0}) $display("FAIL relock_outputs: got %b %h %b want 00 00 0", state_dbg, led, unlocked); else n_pass++;
      tick(10);
   endtask

   task automatic test_bounce;
      int opens   = 0;
      int changes = 0;
      logic [1:0] prev;
      prev    = state_dbg;
      in_code = 8'h00;
      for (int k = 0; k < 20; k++) begin
         if (k < 10) submit_n = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
         else        submit_n = 1'b0;
         @(negedge clk);
         if (state_dbg !== prev) begin
            changes++;
            if (state_dbg === OPEN) opens++;
            prev = state_dbg;
         end
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (state_dbg !== prev) begin
            changes++;
            if (state_dbg === OPEN) opens++;
            prev = state_dbg;
         end
      end
      submit_n = 1'b1;
      n_total++; if (opens !== 1) $display("FAIL bounce_opens: got %0d want 1", opens); else n_pass++;
      n_total++; if (changes !== 2) $display("FAIL bounce_transitions: got %0d want 2", changes); else n_pass++;
      tick(10);
      n_total++; if ({state_dbg, tries_dbg} !== {CLOSED, 2'd0}) $display("FAIL bounce_end: got %b %0d want 00 0", state_dbg, tries_dbg); else n_pass++;
   endtask

   task automatic test_alarm;
      int lat;
      int n_alarm;
      int bad = 0;
      logic [7:0] exp_led;
      in_code = 8'h5A;
      press_submit(8);
      n_total++; if ({state_dbg, tries_dbg} !== {CLOSED, 2'd1}) $display("FAIL wrong1: got %b %0d want 00 1", state_dbg, tries_dbg); else n_pass++;
      press_submit(8);
      n_total++; if ({state_dbg, tries_dbg} !== {CLOSED, 2'd2}) $display("FAIL wrong2: got %b %0d want 00 2", state_dbg, tries_dbg); else n_pass++;
      submit_n = 1'b0;
      wait_state(ALARM, 20, lat);
      n_total++; if (lat !== 7) $display("FAIL alarm_latency: got %0d want 7", lat); else n_pass++;
      n_total++; if ({alarm, unlocked, led, tries_dbg} !== {2'b10, 8'hAA, 2'd3}) $display("FAIL alarm_entry: got %b %b %h %0d want 1 0 aa 3", alarm, unlocked, led, tries_dbg); else n_pass++;
      n_alarm = 1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (state_dbg !== ALARM) break;
         exp_led = ((n_alarm / 5) % 2 == 1) ? 8'h55 : 8'hAA;
         if (led !== exp_led || alarm !== 1'b1) bad++;
         n_alarm++;
         if (n_alarm == 10) submit_n = 1'b1;
         if (n_alarm == 12) mode     = 1'b1;
         if (n_alarm == 15) submit_n = 1'b0;
         if (n_alarm == 25) submit_n = 1'b1;
         if (n_alarm == 30) mode     = 1'b0;
      end
      n_total++; if (n_alarm !== 40) $display("FAIL alarm_dwell: got %0d want 40", n_alarm); else n_pass++;
      n_total++; if (bad !== 0) $display("FAIL alarm_blink: got %0d bad samples want 0", bad); else n_pass++;
      n_total++; if ({state_dbg, tries_dbg, alarm, led} !== {CLOSED, 2'd0, 1'b0, 8'h00}) $display("FAIL alarm_exit: got %b %0d %b %h want 00 0 0 00", state_dbg, tries_dbg, alarm, led); else n_pass++;
      tick(10);
   endtask

   task automatic test_prog;
      int lat;
      in_code  = 8'h00;
      submit_n = 1'b0;
      wait_state(OPEN, 20, lat);
      n_total++; if (lat !== 7) $display("FAIL prog_open_latency: got %0d want 7", lat); else n_pass++;
      submit_n = 1'b1;
      mode     = 1'b1;
      wait_state(PROG, 10, lat);
      n_total++; if (lat !== 3) $display("FAIL prog_entry_latency: got %0d want 3", lat); else n_pass++;
      in_code = 8'h3C;
      tick(1);
      n_total++; if (led !== 8'h3C) $display("FAIL prog_echo: got %h want 3c", led); else n_pass++;
      tick(8);
      press_submit(8);
      n_total++; if (state_dbg !== PROG) $display("FAIL prog_submit_ignored: got %b want %b", state_dbg, PROG); else n_pass++;
      press_save(8);
      n_total++; if (state_dbg !== PROG) $display("FAIL prog_after_save: got %b want %b", state_dbg, PROG); else n_pass++;
      mode = 1'b0;
      wait_state(CLOSED, 10, lat);
      n_total++; if (lat !== 3) $display("FAIL prog_exit_latency: got %0d want 3", lat); else n_pass++;
      in_code = 8'h00;
      press_submit(8);
      n_total++; if ({state_dbg, tries_dbg} !== {CLOSED, 2'd1}) $display("FAIL old_pw_rejected: got %b %0d want 00 1", state_dbg, tries_dbg); else n_pass++;
      in_code  = 8'h3C;
      submit_n = 1'b0;
      wait_state(OPEN, 20, lat);
      n_total++; if (lat !== 7 || tries_dbg !== 2'd0) $display("FAIL new_pw_open: got lat %0d tries %0d want 7 0", lat, tries_dbg); else n_pass++;
      submit_n = 1'b1;
      tick(8);
      submit_n = 1'b0;
      wait_state(CLOSED, 20, lat);
      n_total++; if (lat !== 7) $display("FAIL manual_relock_latency: got %0d want 7", lat); else n_pass++;
      submit_n = 1'b1;
      tick(10);
   endtask

   task automatic test_priority;
      int lat;
      int bad = 0;
      in_code  = 8'h3C;
      submit_n = 1'b0;
      wait_state(OPEN, 20, lat);
      n_total++; if (lat !== 7) $display("FAIL prio_open_latency: got %0d want 7", lat); else n_pass++;
      submit_n = 1'b1;
      tick(8);
      submit_n = 1'b0;
      tick(4);
      mode = 1'b1;
      tick(3);
      n_total++; if (state_dbg !== CLOSED) $display("FAIL submit_over_mode: got %b want %b", state_dbg, CLOSED); else n_pass++;
      submit_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (state_dbg !== CLOSED) bad++;
      end
      in_code = 8'h77;
      save_n  = 1'b0;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (state_dbg !== CLOSED || tries_dbg !== 2'd0) bad++;
         if (i == 8) save_n = 1'b1;
      end
      n_total++; if (bad !== 0) $display("FAIL closed_mode_save: got %0d bad samples want 0", bad); else n_pass++;
      mode = 1'b0;
      tick(4);
      in_code  = 8'h3C;
      submit_n = 1'b0;
      wait_state(OPEN, 20, lat);
      n_total++; if (lat !== 7) $display("FAIL pw_unchanged: got lat %0d want 7", lat); else n_pass++;
      submit_n = 1'b1;
      tick(8);
      submit_n = 1'b0;
      wait_state(CLOSED, 20, lat);
      n_total++; if (lat !== 7) $display("FAIL prio_relock: got %0d want 7", lat); else n_pass++;
      submit_n = 1'b1;
      tick(10);
   endtask

   task automatic test_reset_alarm;
      int lat;
      int bad = 0;
      in_code = 8'h5A;
      press_submit(8);
      press_submit(8);
      submit_n = 1'b0;
      wait_state(ALARM, 20, lat);
      n_total++; if (lat !== 7) $display("FAIL ra_alarm_latency: got %0d want 7", lat); else n_pass++;
      in_code = 8'h00;
      tick(5);
      #3 rst_n = 1'b0;
      #1;
      n_total++; if ({state_dbg, alarm, unlocked, led, tries_dbg} !== {CLOSED, 2'b00, 8'h00, 2'd0}) $display("FAIL async_reset: got %b %b %b %h %0d want 00 0 0 00 0", state_dbg, alarm, unlocked, led, tries_dbg); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (state_dbg !== CLOSED || tries_dbg !== 2'd0) bad++;
      end
      n_total++; if (bad !== 0) $display("FAIL held_through_reset: got %0d bad samples want 0", bad); else n_pass++;
      submit_n = 1'b1;
      tick(10);
      submit_n = 1'b0;
      wait_state(OPEN, 20, lat);
      n_total++; if (lat !== 7) $display("FAIL reset_pw_open: got %0d want 7", lat); else n_pass++;
      submit_n = 1'b1;
      tick(8);
      submit_n = 1'b0;
      wait_state(CLOSED, 20, lat);
      n_total++; if (lat !== 7) $display("FAIL ra_relock: got %0d want 7", lat); else n_pass++;
      submit_n = 1'b1;
      tick(10);
   endtask

   initial begin
      test_reset();
      test_open_timeout();
      test_bounce();
      test_alarm();
      test_prog();
      test_priority();
      test_reset_alarm();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
